audio_sample_packet_decoder: RTL and testbench

Sink-side decoder for HDMI Audio Sample Packets (packet type 0x02, 2-channel layout 0) carrying IEC 60958 frames. It sits after the data-island packet assembler and BCH correction, which hand it one decoded header and four subpackets per packet. It extracts left/right sample words with V/U bits and per-channel parity status into a show-ahead FIFO drained by a valid/ready handshake. It also reassembles the 192-frame IEC 60958 channel-status blocks for both channels.

---
 rtl/audio_sample_packet_decoder.sv | 268 ++++++++++++++++++++++++++
 tb/tb_audio_sample_packet_decoder.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_packet_decoder.sv
// audio_sample_packet_decoder
// Sink-side decoder for HDMI Audio Sample Packets (type 0x02, 2-channel
// layout 0). Subpacket 0 is split into left/right sample words with V/U bits
// and per-channel parity status. These are queued in a show-ahead FIFO
// drained by valid/ready. The IEC 60958 channel-status bits of both channels
// are reassembled into 192-frame blocks.
// Optional feature: define AUDIO_PARITY_CHECK_EN to compute parity_error.
// When it is undefined, parity_error is tied to 2'b00.
module audio_sample_packet_decoder #(
    parameter int FIFO_DEPTH            = 4,
    parameter int CHANNEL_STATUS_LENGTH = 192
) (
    input  logic                             clk_pixel,
    input  logic                             reset_n,
    input  logic                             packet_valid,
    input  logic [23:0]                      header,
    input  logic [3:0][55:0]                 sub,
    output logic                             audio_valid,
    input  logic                             audio_ready,
    output logic [1:0][23:0]                 audio_sample_word,
    output logic [1:0]                       valid_bit,
    output logic [1:0]                       user_data_bit,
    output logic [1:0]                       parity_error,
    output logic [CHANNEL_STATUS_LENGTH-1:0] channel_status_left,
    output logic [CHANNEL_STATUS_LENGTH-1:0] channel_status_right,
    output logic                             channel_status_valid,
    output logic                             overflow,
    output logic                             sync_error
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [7:0]       LAST_INDEX = 8'(CHANNEL_STATUS_LENGTH - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [23:0] right;
        logic [23:0] left;
        logic [1:0]  user;
        logic [1:0]  valid;
        logic [1:0]  perr;
    } entry_t;

    typedef enum logic {
        CS_HUNT    = 1'b0,
        CS_COLLECT = 1'b1
    } cs_state_e;

    // ---------------------------------------------------------------- decode
    logic        w_accept;
    logic        w_process;
    logic        w_b;
    logic [55:0] w_sub0;
    logic [1:0]  w_c;
    logic [1:0]  w_perr;
    logic        w_unused;
    entry_t      w_entry;

    assign w_sub0    = sub[0];
    assign w_accept  = packet_valid && (header[7:0] == 8'h02) && !header[12];
    assign w_process = w_accept && header[8];
    assign w_b       = header[20];
    assign w_c       = {w_sub0[54], w_sub0[50]};

`ifdef AUDIO_PARITY_CHECK_EN
    // Even parity over sample, V, U, C; a set bit means the stored P disagrees.
    assign w_perr[0] = w_sub0[51] ^ (^{w_sub0[50], w_sub0[49], w_sub0[48], w_sub0[23:0]});
    assign w_perr[1] = w_sub0[55] ^ (^{w_sub0[54], w_sub0[53], w_sub0[52], w_sub0[47:24]});
    assign w_unused  = ^{sub[3:1], header[23:21], header[19:16], header[15:13], header[11:9]};
`else
    assign w_perr    = 2'b00;
    assign w_unused  = ^{sub[3:1], header[23:21], header[19:16], header[15:13], header[11:9],
                         w_sub0[55], w_sub0[51]};
`endif

    assign w_entry.right = w_sub0[47:24];
    assign w_entry.left  = w_sub0[23:0];
    assign w_entry.user  = {w_sub0[53], w_sub0[49]};
    assign w_entry.valid = {w_sub0[52], w_sub0[48]};
    assign w_entry.perr  = w_perr;

    // ------------------------------------------------------------------ FIFO
    // Shift-register FIFO: entry 0 is always the head, so the sample outputs
    // come straight from flops. Slots at or above the count are kept at zero.
    entry_t           r_mem [FIFO_DEPTH];
    entry_t           w_mem_next [FIFO_DEPTH];
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [PTR_W-1:0] w_wr_idx;
    logic             r_valid;
    logic             r_overflow;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    assign w_full   = (r_count == FULL_COUNT);
    assign w_pop    = r_valid && audio_ready;
    assign w_push   = w_process && (!w_full || w_pop);
    assign w_wr_idx = PTR_W'(r_count - CNT_W'(w_pop));

    // Next FIFO contents: shift down on pop, then write the new entry above the survivors
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so that no path leaves it unassigned and infers a latch.
        w_mem_next = r_mem;
        if (w_pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                w_mem_next[i] = r_mem[i + 1];
            end
            w_mem_next[FIFO_DEPTH-1] = '0;
        end
        if (w_push) begin
            w_mem_next[w_wr_idx] = w_entry;
        end
    end

    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // FIFO storage, occupancy, head-valid flag and overflow pulse
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: this storage is reset because entry 0 drives the outputs,
            // which must read zero after reset; a plain RAM would not be reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_mem      <= w_mem_next;
            r_count    <= w_count_next;
            r_valid    <= (w_count_next != '0);
            r_overflow <= w_process && w_full && !w_pop;
        end
    end

    assign audio_valid          = r_valid;
    assign audio_sample_word[0] = r_mem[0].left;
    assign audio_sample_word[1] = r_mem[0].right;
    assign valid_bit            = r_mem[0].valid;
    assign user_data_bit        = r_mem[0].user;
    assign parity_error         = r_mem[0].perr;
    assign overflow             = r_overflow;

    // -------------------------------------------------- channel-status FSM
    cs_state_e                  r_state;
    cs_state_e                  w_state_next;
    logic [7:0]                 r_index;
    logic [7:0]                 w_index_next;
    logic                       w_cs_start;
    logic                       w_cs_write;
    logic                       w_cs_done;
    logic                       w_sync_err;
    logic [CHANNEL_STATUS_LENGTH-1:0] r_shadow_l;
    logic [CHANNEL_STATUS_LENGTH-1:0] r_shadow_r;
    logic [CHANNEL_STATUS_LENGTH-1:0] w_done_l;
    logic [CHANNEL_STATUS_LENGTH-1:0] w_done_r;
    logic [CHANNEL_STATUS_LENGTH-1:0] r_status_l;
    logic [CHANNEL_STATUS_LENGTH-1:0] r_status_r;
    logic                       r_status_valid;
    logic                       r_sync_error;

    // State register: FSM state and frame index within the current block
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CS_HUNT;
            r_index <= '0;
        end else begin
            r_state <= w_state_next;
            r_index <= w_index_next;
        end
    end

    // Next-state logic: block framing driven by the B flag of processed frames
    always_comb begin
        w_state_next = r_state;
        w_index_next = r_index;
        if (w_process) begin
            case (r_state)
                CS_HUNT: begin
                    if (w_b) begin
                        w_state_next = CS_COLLECT;
                        w_index_next = 8'd1;
                    end
                end
                CS_COLLECT: begin
                    if (w_b) begin
                        w_index_next = 8'd1;
                    end else if (r_index == 8'd0) begin
                        w_state_next = CS_HUNT;
                    end else if (r_index == LAST_INDEX) begin
                        w_index_next = 8'd0;
                    end else begin
                        w_index_next = r_index + 8'd1;
                    end
                end
                default: w_state_next = CS_HUNT;
            endcase
        end
    end

    // Output logic: shadow write strobes, block completion and framing errors
    always_comb begin
        w_cs_start = 1'b0;
        w_cs_write = 1'b0;
        w_cs_done  = 1'b0;
        w_sync_err = 1'b0;
        if (w_process) begin
            case (r_state)
                CS_HUNT: w_cs_start = w_b;
                CS_COLLECT: begin
                    if (w_b) begin
                        w_cs_start = 1'b1;
                        w_sync_err = (r_index != 8'd0);
                    end else if (r_index == 8'd0) begin
                        w_sync_err = 1'b1;
                    end else begin
                        w_cs_write = 1'b1;
                        w_cs_done  = (r_index == LAST_INDEX);
                    end
                end
                default: ;
            endcase
        end
    end

    // Completed block images: the shadows with the final frame's bits merged in
    always_comb begin
        w_done_l = r_shadow_l;
        w_done_r = r_shadow_r;
        w_done_l[CHANNEL_STATUS_LENGTH-1] = w_c[0];
        w_done_r[CHANNEL_STATUS_LENGTH-1] = w_c[1];
    end

    // Shadow accumulation and publication of completed blocks
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow_l     <= '0;
            r_shadow_r     <= '0;
            r_status_l     <= '0;
            r_status_r     <= '0;
            r_status_valid <= 1'b0;
            r_sync_error   <= 1'b0;
        end else begin
            if (w_cs_start) begin
                // A new block clears every bit not yet written.
                r_shadow_l <= CHANNEL_STATUS_LENGTH'(w_c[0]);
                r_shadow_r <= CHANNEL_STATUS_LENGTH'(w_c[1]);
            end else if (w_cs_write) begin
                r_shadow_l[r_index] <= w_c[0];
                r_shadow_r[r_index] <= w_c[1];
            end
            if (w_cs_done) begin
                r_status_l <= w_done_l;
                r_status_r <= w_done_r;
            end
            r_status_valid <= w_cs_done;
            r_sync_error   <= w_sync_err;
        end
    end

    assign channel_status_left  = r_status_l;
    assign channel_status_right = r_status_r;
    assign channel_status_valid = r_status_valid;
    assign sync_error           = r_sync_error;

endmodule

// File: tb/tb_audio_sample_packet_decoder.sv
// Directed testbench for audio_sample_packet_decoder.
// Parity expectations follow AUDIO_PARITY_CHECK_EN the same way the design does.
module tb_audio_sample_packet_decoder;

    localparam int LEN = 192;
    localparam logic [23:0] HDR_B  = 24'h10_01_02;  // B=1, sp0 present
    localparam logic [23:0] HDR_NB = 24'h00_01_02;  // B=0, sp0 present

    logic             clk_pixel;
    logic             reset_n;
    logic             packet_valid;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic             audio_valid;
    logic             audio_ready;
    logic [1:0][23:0] audio_sample_word;
    logic [1:0]       valid_bit;
    logic [1:0]       user_data_bit;
    logic [1:0]       parity_error;
    logic [LEN-1:0]   channel_status_left;
    logic [LEN-1:0]   channel_status_right;
    logic             channel_status_valid;
    logic             overflow;
    logic             sync_error;

    int n_cmp = 0;
    int n_err = 0;
    int cnt_csv = 0;
    int cnt_sync = 0;
    int cnt_ovf = 0;

    audio_sample_packet_decoder #(
        .FIFO_DEPTH(4),
        .CHANNEL_STATUS_LENGTH(LEN)
    ) dut (
        .clk_pixel(clk_pixel),
        .reset_n(reset_n),
        .packet_valid(packet_valid),
        .header(header),
        .sub(sub),
        .audio_valid(audio_valid),
        .audio_ready(audio_ready),
        .audio_sample_word(audio_sample_word),
        .valid_bit(valid_bit),
        .user_data_bit(user_data_bit),
        .parity_error(parity_error),
        .channel_status_left(channel_status_left),
        .channel_status_right(channel_status_right),
        .channel_status_valid(channel_status_valid),
        .overflow(overflow),
        .sync_error(sync_error)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    // Pulse counters; at the rising edge the outputs still hold the previous cycle's value.
    always @(posedge clk_pixel) begin
        if (channel_status_valid === 1'b1) cnt_csv++;
        if (sync_error === 1'b1) cnt_sync++;
        if (overflow === 1'b1) cnt_ovf++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Subpacket 0 with correct even parity on both channels.
    function automatic logic [55:0] mk_sub(input logic [23:0] l, input logic [23:0] r,
                                           input logic c0, input logic c1);
        logic p0, p1;
        p0 = ^{c0, 1'b0, 1'b0, l};
        p1 = ^{c1, 1'b0, 1'b0, r};
        return {p1, c1, 1'b0, 1'b0, p0, c0, 1'b0, 1'b0, r, l};
    endfunction

    // Callers are at a falling edge; returns at the falling edge after capture.
    task automatic send(input logic [23:0] hdr, input logic [55:0] s0);
        packet_valid = 1'b1;
        header       = hdr;
        sub          = '0;
        sub[0]       = s0;
        @(negedge clk_pixel);
        packet_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        packet_valid = 1'b0;
        audio_ready  = 1'b0;
        header       = '0;
        sub          = '0;
        repeat (2) @(negedge clk_pixel);
        reset_n = 1'b1;
        @(negedge clk_pixel);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (audio_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_audio_valid: got %b want 0", audio_valid);
        end
        n_cmp++;
        if (audio_sample_word !== 48'h0) begin
            n_err++; $display("FAIL reset_samples: got %h want 0", audio_sample_word);
        end
        n_cmp++;
        if ({valid_bit, user_data_bit, parity_error} !== 6'b0) begin
            n_err++; $display("FAIL reset_bits: got %b want 000000", {valid_bit, user_data_bit, parity_error});
        end
        n_cmp++;
        if (channel_status_left !== '0 || channel_status_right !== '0) begin
            n_err++; $display("FAIL reset_status: left %h right %h want 0", channel_status_left, channel_status_right);
        end
        n_cmp++;
        if ({channel_status_valid, overflow, sync_error} !== 3'b000) begin
            n_err++; $display("FAIL reset_pulses: got %b want 000", {channel_status_valid, overflow, sync_error});
        end
    endtask

    task automatic test_single_packet();
        do_reset();
        // L=123456 and R=ABCDEF both have odd popcount, so P0=P1=1.
        send(HDR_B, 56'h88_ABCDEF_123456);
        n_cmp++;
        if (audio_valid !== 1'b1) begin
            n_err++; $display("FAIL single_valid: got %b want 1", audio_valid);
        end
        n_cmp++;
        if (audio_sample_word[0] !== 24'h123456 || audio_sample_word[1] !== 24'hABCDEF) begin
            n_err++; $display("FAIL single_samples: got L=%h R=%h want L=123456 R=abcdef",
                              audio_sample_word[0], audio_sample_word[1]);
        end
        n_cmp++;
        if (parity_error !== 2'b00) begin
            n_err++; $display("FAIL single_parity: got %b want 00", parity_error);
        end
        @(negedge clk_pixel);
        n_cmp++;
        if (audio_valid !== 1'b1 || audio_sample_word[0] !== 24'h123456) begin
            n_err++; $display("FAIL single_hold: valid %b L=%h want 1 / 123456", audio_valid, audio_sample_word[0]);
        end
        audio_ready = 1'b1;
        @(negedge clk_pixel);
        audio_ready = 1'b0;
        n_cmp++;
        if (audio_valid !== 1'b0) begin
            n_err++; $display("FAIL single_drain: got %b want 0", audio_valid);
        end
    endtask

    task automatic test_parity();
        logic [1:0] exp_perr;
`ifdef AUDIO_PARITY_CHECK_EN
        exp_perr = 2'b01;
`else
        exp_perr = 2'b00;
`endif
        do_reset();
        send(HDR_B, 56'h80_ABCDEF_123456);
        n_cmp++;
        if (audio_valid !== 1'b1 || parity_error !== exp_perr) begin
            n_err++; $display("FAIL parity_p0_flip: valid %b perr %b want 1 / %b", audio_valid, parity_error, exp_perr);
        end
    endtask

    task automatic test_channel_status();
        logic [LEN-1:0] exp_l, exp_r;
        int csv0, sync0;
        do_reset();
        audio_ready = 1'b1;
        csv0 = cnt_csv;
        sync0 = cnt_sync;
        for (int k = 0; k < LEN; k++) begin
            send((k == 0) ? HDR_B : HDR_NB,
                 mk_sub(24'(k), 24'(k + 1000), (k == 1 || k == 20), (k == 21)));
            if (k == LEN - 2) begin
                n_cmp++;
                if (channel_status_valid !== 1'b0) begin
                    n_err++; $display("FAIL cs_early_pulse: got %b want 0", channel_status_valid);
                end
            end
        end
        n_cmp++;
        if (channel_status_valid !== 1'b1) begin
            n_err++; $display("FAIL cs_pulse_timing: got %b want 1", channel_status_valid);
        end
        exp_l = '0; exp_l[1] = 1'b1; exp_l[20] = 1'b1;
        exp_r = '0; exp_r[21] = 1'b1;
        n_cmp++;
        if (channel_status_left !== exp_l) begin
            n_err++; $display("FAIL cs_left: got %h want %h", channel_status_left, exp_l);
        end
        n_cmp++;
        if (channel_status_right !== exp_r) begin
            n_err++; $display("FAIL cs_right: got %h want %h", channel_status_right, exp_r);
        end
        // After bit 191 the next frame must carry B; B=0 is a framing error.
        send(HDR_NB, mk_sub(24'h1, 24'h2, 1'b0, 1'b0));
        n_cmp++;
        if (sync_error !== 1'b1) begin
            n_err++; $display("FAIL cs_missing_b: got %b want 1", sync_error);
        end
        repeat (2) @(negedge clk_pixel);
        audio_ready = 1'b0;
        n_cmp++;
        if (cnt_csv - csv0 !== 1 || cnt_sync - sync0 !== 1) begin
            n_err++; $display("FAIL cs_pulse_counts: csv %0d sync %0d want 1 / 1", cnt_csv - csv0, cnt_sync - sync0);
        end
    endtask

    task automatic test_sync_error();
        logic [LEN-1:0] exp_l, exp_r;
        int csv0, sync0;
        do_reset();
        audio_ready = 1'b1;
        csv0 = cnt_csv;
        sync0 = cnt_sync;
        for (int k = 0; k < 100; k++) begin
            send((k == 0) ? HDR_B : HDR_NB, mk_sub(24'(k), 24'(k), (k == 5), 1'b0));
        end
        // Premature B at frame 100 restarts the block with this frame as bit 0.
        send(HDR_B, mk_sub(24'h64, 24'h64, 1'b1, 1'b0));
        n_cmp++;
        if (sync_error !== 1'b1) begin
            n_err++; $display("FAIL sync_pulse: got %b want 1", sync_error);
        end
        n_cmp++;
        if (channel_status_left !== '0 || channel_status_valid !== 1'b0) begin
            n_err++; $display("FAIL sync_outputs_held: left %h csv %b want 0 / 0", channel_status_left, channel_status_valid);
        end
        for (int k = 1; k < LEN; k++) begin
            send(HDR_NB, mk_sub(24'(k), 24'(k), 1'b0, (k == 3)));
        end
        n_cmp++;
        if (channel_status_valid !== 1'b1) begin
            n_err++; $display("FAIL sync_recover_pulse: got %b want 1", channel_status_valid);
        end
        exp_l = '0; exp_l[0] = 1'b1;
        exp_r = '0; exp_r[3] = 1'b1;
        n_cmp++;
        if (channel_status_left !== exp_l || channel_status_right !== exp_r) begin
            n_err++; $display("FAIL sync_recover_status: left %h right %h want %h / %h",
                              channel_status_left, channel_status_right, exp_l, exp_r);
        end
        repeat (2) @(negedge clk_pixel);
        audio_ready = 1'b0;
        n_cmp++;
        if (cnt_csv - csv0 !== 1 || cnt_sync - sync0 !== 1) begin
            n_err++; $display("FAIL sync_counts: csv %0d sync %0d want 1 / 1", cnt_csv - csv0, cnt_sync - sync0);
        end
    endtask

    task automatic test_overflow();
        logic [23:0] exp_l;
        int ovf0;
        do_reset();
        ovf0 = cnt_ovf;
        for (int i = 1; i <= 5; i++) begin
            send(HDR_NB, mk_sub(24'(i) * 24'h111111, 24'h0, 1'b0, 1'b0));
            if (i == 4 || i == 5) begin
                n_cmp++;
                if (overflow !== (i == 5)) begin
                    n_err++; $display("FAIL ovf_pulse_%0d: got %b want %b", i, overflow, (i == 5));
                end
            end
        end
        audio_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp_l = 24'(i) * 24'h111111;
            n_cmp++;
            if (audio_valid !== 1'b1 || audio_sample_word[0] !== exp_l) begin
                n_err++; $display("FAIL ovf_drain_%0d: valid %b L=%h want 1 / %h", i, audio_valid, audio_sample_word[0], exp_l);
            end
            @(negedge clk_pixel);
        end
        audio_ready = 1'b0;
        n_cmp++;
        if (audio_valid !== 1'b0 || cnt_ovf - ovf0 !== 1) begin
            n_err++; $display("FAIL ovf_empty: valid %b pulses %0d want 0 / 1", audio_valid, cnt_ovf - ovf0);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_l;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            send(HDR_NB, mk_sub(24'(i), 24'h0, 1'b0, 1'b0));
        end
        // Full FIFO: simultaneous pop and push are both honoured.
        audio_ready = 1'b1;
        send(HDR_NB, mk_sub(24'd5, 24'h0, 1'b0, 1'b0));
        audio_ready = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0 || audio_sample_word[0] !== 24'd2) begin
            n_err++; $display("FAIL b2b_full_pushpop: ovf %b head %h want 0 / 000002", overflow, audio_sample_word[0]);
        end
        audio_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            exp_l = 24'(i);
            n_cmp++;
            if (audio_valid !== 1'b1 || audio_sample_word[0] !== exp_l) begin
                n_err++; $display("FAIL b2b_order_%0d: valid %b L=%h want 1 / %h", i, audio_valid, audio_sample_word[0], exp_l);
            end
            @(negedge clk_pixel);
        end
        audio_ready = 1'b0;
        n_cmp++;
        if (audio_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_empty: got %b want 0", audio_valid);
        end
    endtask

    task automatic test_ignored();
        int sync0;
        do_reset();
        sync0 = cnt_sync;
        send(HDR_B, mk_sub(24'hAAAAAA, 24'h0, 1'b0, 1'b0));  // starts a block, index 1
        // Each would be a sync error or a push if it were wrongly accepted.
        send(24'h10_01_01, mk_sub(24'h111111, 24'h0, 1'b0, 1'b0));  // wrong packet type
        send(24'h10_11_02, mk_sub(24'h222222, 24'h0, 1'b0, 1'b0));  // layout 1
        send(24'h10_00_02, mk_sub(24'h333333, 24'h0, 1'b0, 1'b0));  // sp0 absent
        repeat (2) @(negedge clk_pixel);
        n_cmp++;
        if (cnt_sync - sync0 !== 0) begin
            n_err++; $display("FAIL ignored_sync: got %0d pulses want 0", cnt_sync - sync0);
        end
        n_cmp++;
        if (audio_valid !== 1'b1 || audio_sample_word[0] !== 24'hAAAAAA) begin
            n_err++; $display("FAIL ignored_head: valid %b L=%h want 1 / aaaaaa", audio_valid, audio_sample_word[0]);
        end
        audio_ready = 1'b1;
        @(negedge clk_pixel);
        audio_ready = 1'b0;
        n_cmp++;
        if (audio_valid !== 1'b0) begin
            n_err++; $display("FAIL ignored_no_push: got %b want 0", audio_valid);
        end
    endtask

    task automatic test_reset_mid_block();
        int sync0;
        do_reset();
        send(HDR_B, mk_sub(24'h010101, 24'h0, 1'b1, 1'b0));
        for (int k = 1; k < 4; k++) begin
            send(HDR_NB, mk_sub(24'(k), 24'h0, 1'b0, 1'b0));
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (audio_valid !== 1'b0 || audio_sample_word !== 48'h0) begin
            n_err++; $display("FAIL midreset_async: valid %b samples %h want 0 / 0", audio_valid, audio_sample_word);
        end
        @(negedge clk_pixel);
        reset_n = 1'b1;
        @(negedge clk_pixel);
        sync0 = cnt_sync;
        // From HUNT a B frame starts a block cleanly; from mid-block it would be a sync error.
        send(HDR_B, mk_sub(24'h0F0F0F, 24'h0, 1'b0, 1'b0));
        repeat (2) @(negedge clk_pixel);
        n_cmp++;
        if (cnt_sync - sync0 !== 0) begin
            n_err++; $display("FAIL midreset_hunt: got %0d sync pulses want 0", cnt_sync - sync0);
        end
        n_cmp++;
        if (audio_valid !== 1'b1 || audio_sample_word[0] !== 24'h0F0F0F) begin
            n_err++; $display("FAIL midreset_flush: valid %b L=%h want 1 / 0f0f0f", audio_valid, audio_sample_word[0]);
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        packet_valid = 1'b0;
        audio_ready  = 1'b0;
        header       = '0;
        sub          = '0;
        @(negedge clk_pixel);
        test_reset();
        test_single_packet();
        test_parity();
        test_channel_status();
        test_sync_error();
        test_overflow();
        test_back_to_back();
        test_ignored();
        test_reset_mid_block();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
